// File: rtl/alu_pkg.sv
// Shared ALU definitions: the operation codes driven by the ALU control decoder
// and the state encoding of the execution unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADDI = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done_o pulses during the last iteration with product_o already including
// that iteration's partial sum, so the caller latches it on the same edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Partial sum for the current iteration; only the low WIDTH bits are kept.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = acc_d;

  // Load on start, then shift one multiplier bit per cycle until the count expires.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CNT_W'(WIDTH - 1);
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// EX-stage execution unit. Single-cycle ADD/ADDI/SUB/AND/OR and illegal codes,
// iterative MUL through alu_mul_iter. valid/ready on both sides; all outputs
// are registered or decoded from state.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH:0]   op_res;

  // Single-cycle operations; returns {illegal, result}. Arithmetic wraps.
  function automatic logic [WIDTH:0] alu_op(input logic [2:0] code,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (code)
      ALU_ADDI, ALU_ADD: r = {1'b0, a + b};
      ALU_SUB:           r = {1'b0, a + ~b + WIDTH'(1)};
      ALU_AND:           r = {1'b0, a & b};
      ALU_OR:            r = {1'b0, a | b};
      default:           r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mul_start),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Next-state and result-capture logic for IDLE -> (MUL) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    mul_start = 1'b0;
    op_res    = '0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            op_res    = alu_op(ALUCtrl_i, data1_i, data2_i);
            result_d  = op_res[WIDTH-1:0];
            illegal_d = op_res[WIDTH];
            zero_d    = (op_res[WIDTH-1:0] == '0);
            state_d   = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d  = mul_product;
          illegal_d = 1'b0;
          zero_d    = (mul_product == '0);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign ready_o   = (state_q == ST_IDLE);
  assign valid_o   = (state_q == ST_DONE);
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule
